// File: rtl/inst_sequencer_pkg.sv
// Shared definitions for the layer instruction sequencer: FSM states,
// instruction-word bit positions and the idle instruction value.
package inst_sequencer_pkg;

  typedef enum logic [3:0] {
    IDLE, KRD, KVAL, KFLUSH, KPUSH, ARD, AVAL, AFLUSH, EXEC, DRAIN, DONE
  } state_t;

  localparam int INST_W     = 36;
  localparam int B_KLOAD    = 0;
  localparam int B_EXEC     = 1;
  localparam int B_L0_RD    = 3;
  localparam int B_OFIFO_RD = 6;
  localparam int B_XADDR_LO = 7;
  localparam int B_XADDR_HI = 17;
  localparam int B_WEN_X    = 18;
  localparam int B_CEN_X    = 19;
  localparam int B_PADDR_LO = 20;
  localparam int B_PADDR_HI = 30;
  localparam int B_WEN_P    = 31;
  localparam int B_CEN_P    = 32;
  localparam int B_ACCUM    = 33;
  localparam int B_RELU     = 34;
  localparam int B_HUFF_DV  = 35;

  // Both SRAMs deselected and write-disabled, everything else clear.
  localparam logic [INST_W-1:0] IDLE_INST = 36'h1_800C_0000;

  // xmem address field: top bit selects the L0 path and is always 0.
  function automatic logic [10:0] xmem_field(input logic [9:0] addr);
    return {1'b0, addr};
  endfunction

endpackage

// File: rtl/seq_counter.sv
// Loadable up-counter with a terminal-count flag (count == tc_val).
module seq_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] tc_val,
  output logic [W-1:0] count,
  output logic         tc
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (en) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;
  assign tc    = (count_reg == tc_val);

endmodule

// File: rtl/inst_sequencer.sv
// Layer instruction sequencer: kernel load, activation stream, execute, psum drain.
// Define RELU_EN to raise relu_valid on every psum write cycle.
module inst_sequencer
  import inst_sequencer_pkg::*;
#(
  parameter int row      = 8,
  parameter int col      = 8,
  parameter int HUFF_LAT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [9:0]  kbase,
  input  logic [9:0]  abase,
  input  logic [10:0] pbase,
  input  logic [10:0] a_words,
  input  logic        data_ready_huff,
  input  logic        ofifo_valid,
  output logic [35:0] inst,
  output logic        busy,
  output logic        done
);

  localparam int CW_RAW = $clog2(1024 + row + col + HUFF_LAT);
  localparam int CW     = (CW_RAW > 11) ? CW_RAW : 11;

  localparam logic [9:0]    K_LAST     = 10'(col - 1);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(HUFF_LAT - 1);
  localparam logic [CW-1:0] KPUSH_LAST = CW'(row + col - 1);

  state_t state_reg, state_next;

  logic [9:0]  kbase_reg, abase_reg;
  logic [10:0] pbase_reg, n_reg;
  logic [35:0] inst_reg, inst_next;
  logic        busy_reg, done_reg;
  logic        accept;

  // Word counter: xmem read offset within the kernel / activation phase.
  logic        w_load, w_en, w_tc;
  logic [9:0]  w_tc_val, w_count;
  // Cycle counter: flush, kernel push and execute lengths, then drain index k.
  logic          c_load, c_en, c_tc;
  logic [CW-1:0] c_tc_val, c_count;

  logic [9:0]    kptr, aptr, a_last;
  logic [10:0]   pptr;
  logic [CW-1:0] exec_last, drain_last;

  assign kptr       = kbase_reg + w_count;
  assign aptr       = abase_reg + w_count;
  assign pptr       = pbase_reg + c_count[10:0];
  assign a_last     = n_reg[9:0] - 10'd1;
  assign exec_last  = CW'(n_reg) + CW'(row + col) - CW'(1);
  assign drain_last = CW'(n_reg) - CW'(1);

  seq_counter #(.W(10)) u_word_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (w_load),
    .load_val ('0),
    .en       (w_en),
    .tc_val   (w_tc_val),
    .count    (w_count),
    .tc       (w_tc)
  );

  seq_counter #(.W(CW)) u_cycle_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (c_load),
    .load_val ('0),
    .en       (c_en),
    .tc_val   (c_tc_val),
    .count    (c_count),
    .tc       (c_tc)
  );

  always_comb begin
    state_next = state_reg;
    inst_next  = IDLE_INST;
    accept     = 1'b0;
    w_load     = 1'b0;
    w_en       = 1'b0;
    w_tc_val   = a_last;
    c_load     = 1'b0;
    c_en       = 1'b0;
    c_tc_val   = FLUSH_LAST;

    case (state_reg)
      IDLE: begin
        if (start && !busy_reg) begin
          accept     = 1'b1;
          w_load     = 1'b1;
          c_load     = 1'b1;
          state_next = KRD;
        end
      end

      KRD, ARD: begin
        inst_next[B_CEN_X] = 1'b0;
        inst_next[B_XADDR_HI:B_XADDR_LO] = xmem_field((state_reg == KRD) ? kptr : aptr);
        state_next = (state_reg == KRD) ? KVAL : AVAL;
      end

      // Address is kept on the bus with CEN high so the SRAM holds Q.
      KVAL, AVAL: begin
        inst_next[B_HUFF_DV] = 1'b1;
        inst_next[B_XADDR_HI:B_XADDR_LO] = xmem_field((state_reg == KVAL) ? kptr : aptr);
        w_tc_val = (state_reg == KVAL) ? K_LAST : a_last;
        if (data_ready_huff) begin
          if (w_tc) begin
            w_load     = 1'b1;
            state_next = (state_reg == KVAL) ? KFLUSH : AFLUSH;
          end else begin
            w_en       = 1'b1;
            state_next = (state_reg == KVAL) ? KRD : ARD;
          end
        end
      end

      KFLUSH, AFLUSH: begin
        c_en = 1'b1;
        if (c_tc) begin
          c_load     = 1'b1;
          state_next = (state_reg == KFLUSH) ? KPUSH : EXEC;
        end
      end

      KPUSH: begin
        inst_next[B_KLOAD] = 1'b1;
        inst_next[B_L0_RD] = 1'b1;
        c_tc_val = KPUSH_LAST;
        c_en     = 1'b1;
        if (c_tc) begin
          c_load     = 1'b1;
          state_next = ARD;
        end
      end

      EXEC: begin
        inst_next[B_EXEC]  = 1'b1;
        inst_next[B_L0_RD] = 1'b1;
        c_tc_val = exec_last;
        c_en     = 1'b1;
        if (c_tc) begin
          c_load     = 1'b1;
          state_next = DRAIN;
        end
      end

      // The pmem address tracks pbase+k even on stall cycles; only the
      // enables and ofifo_rd depend on ofifo_valid.
      DRAIN: begin
        inst_next[B_PADDR_HI:B_PADDR_LO] = pptr;
        c_tc_val = drain_last;
        if (ofifo_valid) begin
          inst_next[B_OFIFO_RD] = 1'b1;
          inst_next[B_CEN_P]    = 1'b0;
          inst_next[B_WEN_P]    = 1'b0;
`ifdef RELU_EN
          inst_next[B_RELU]     = 1'b1;
`endif
          c_en = 1'b1;
          if (c_tc) begin
            c_load     = 1'b1;
            state_next = DONE;
          end
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      inst_reg  <= IDLE_INST;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      kbase_reg <= '0;
      abase_reg <= '0;
      pbase_reg <= '0;
      n_reg     <= '0;
    end else begin
      state_reg <= state_next;
      inst_reg  <= inst_next;
      busy_reg  <= (state_next != IDLE);
      done_reg  <= (state_reg == DONE);
      if (accept) begin
        kbase_reg <= kbase;
        abase_reg <= abase;
        pbase_reg <= pbase;
        n_reg     <= a_words;
      end
    end
  end

  assign inst = inst_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_inst_sequencer.sv
// Scoreboard bench for inst_sequencer: stimulus queues expected xmem reads,
// pmem writes and per-layer phase lengths; a monitor checks the inst stream.
module tb_inst_sequencer;

  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int HL  = 4;
  localparam logic [35:0] IDLE_W = 36'h1_800C_0000;
`ifdef RELU_EN
  localparam int RELU_EXP = 1;
`else
  localparam int RELU_EXP = 0;
`endif

  typedef struct {
    int n;
    int kp;
    int ex;
    int pb;
  } layer_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  kbase = '0;
  logic [9:0]  abase = '0;
  logic [10:0] pbase = '0;
  logic [10:0] a_words = 11'd1;
  logic        data_ready_huff = 1'b1;
  logic        ofifo_valid = 1'b1;
  logic [35:0] inst;
  logic        busy;
  logic        done;

  inst_sequencer #(.row(ROW), .col(COL), .HUFF_LAT(HL)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .kbase           (kbase),
    .abase           (abase),
    .pbase           (pbase),
    .a_words         (a_words),
    .data_ready_huff (data_ready_huff),
    .ofifo_valid     (ofifo_valid),
    .inst            (inst),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  int     rd_q[$];
  int     wr_q[$];
  layer_t lay_q[$];

  bit mon_en = 1'b0;
  bit drain_flag = 1'b0;
  int kp_cnt = 0, ex_cnt = 0, wr_cnt = 0, rd_cnt = 0, dv3 = 0, gap = 0;
  int last_rd = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic clear_mon();
    kp_cnt = 0; ex_cnt = 0; wr_cnt = 0; rd_cnt = 0; dv3 = 0;
    drain_flag = 1'b0;
  endtask

  // Monitor: one pass per cycle, 1 time unit after the rising edge.
  always @(posedge clk) begin : monitor
    layer_t cur;
    bit     have;
    int     xa, pa;
    #1;
    if (mon_en && reset) begin
      have = (lay_q.size() != 0);
      if (have) cur = lay_q[0];
      xa = int'(inst[16:7]);
      pa = int'(inst[30:20]);
      check("reserved_bits", {inst[2], inst[5:4], inst[17], inst[33]}, 0);

      if (!inst[19]) begin
        check("xmem_wen_on_read", inst[18], 1);
        if (rd_q.size() == 0) check("xmem_rd_extra", xa, -1);
        else check("xmem_rd_addr", xa, rd_q.pop_front());
        last_rd = xa;
        rd_cnt++;
      end

      if (inst[0] && kp_cnt == 0) check("kflush_len", gap, HL);
      if (inst[1] && ex_cnt == 0) check("aflush_len", gap, HL);
      if (inst[35]) begin
        check("dv_hold_q", {inst[19], inst[16:7]}, {1'b1, 10'(last_rd)});
        if (rd_cnt == 3) dv3++;
        gap = 0;
      end else begin
        gap++;
      end

      if (inst[0]) begin
        check("kpush_l0rd", inst[3], 1);
        kp_cnt++;
      end
      if (inst[1]) begin
        check("exec_l0rd", inst[3], 1);
        ex_cnt++;
      end

      if (!inst[32]) begin
        check("pmem_wen_ofifo_rd", {inst[31], inst[6]}, 1);
        check("relu_on_write", inst[34], RELU_EXP);
        if (wr_q.size() == 0) check("pmem_wr_extra", pa, -1);
        else check("pmem_wr_addr", pa, wr_q.pop_front());
        wr_cnt++;
      end else begin
        check("no_write_flags", {inst[6], inst[34]}, 0);
        if (have && !inst[1] && ex_cnt == cur.ex && wr_cnt < cur.n)
          check("drain_hold_addr", pa, (cur.pb + wr_cnt) % 2048);
      end

      if (done) begin
        if (!have) begin
          check("done_unexpected", done, 0);
        end else begin
          void'(lay_q.pop_front());
          check("layer_kpush_cycles", kp_cnt, cur.kp);
          check("layer_exec_cycles", ex_cnt, cur.ex);
          check("layer_writes", wr_cnt, cur.n);
          check("layer_reads_left", rd_q.size(), 0);
        end
        clear_mon();
        have = 1'b0;
      end

      drain_flag = have && (ex_cnt == cur.ex) && (wr_cnt < cur.n);
    end
  end

  // mode: 0 all-ready, 1 random, 2 kernel stall, 3 ofifo pattern,
  //       4 abort in execute, 5 random with start pulse while busy
  task automatic run_layer(input int kb, input int ab, input int pb, input int n, input int mode);
    layer_t L;
    bit got_done = 1'b0;
    bit aborted = 1'b0;
    bit stall_started = 1'b0;
    bit stall_checked = 1'b0;
    int stall_left = 0;
    int pidx = 0;
    int cyc = 0;
    int pat[4] = '{1, 0, 0, 1};

    for (int i = 0; i < COL; i++) rd_q.push_back((kb + i) % 1024);
    for (int i = 0; i < n; i++) rd_q.push_back((ab + i) % 1024);
    for (int i = 0; i < n; i++) wr_q.push_back((pb + i) % 2048);
    L.n = n; L.kp = ROW + COL; L.ex = n + ROW + COL; L.pb = pb;
    lay_q.push_back(L);

    kbase = 10'(kb); abase = 10'(ab); pbase = 11'(pb); a_words = 11'(n);
    data_ready_huff = 1'b1; ofifo_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    kbase = 10'($urandom); abase = 10'($urandom);
    pbase = 11'($urandom); a_words = 11'($urandom_range(1, 1023));

    while (!got_done && !aborted && cyc < 4000) begin
      case (mode)
        0: begin data_ready_huff = 1'b1; ofifo_valid = 1'b1; end
        2: begin
          if (!stall_started && rd_cnt == 3) begin
            stall_started = 1'b1;
            stall_left = 5;
          end
          if (!stall_checked && rd_cnt == 4) begin
            stall_checked = 1'b1;
            check("stall_dv_cycles", dv3, 6);
          end
          data_ready_huff = (stall_left > 0) ? 1'b0 : 1'b1;
          if (stall_left > 0) stall_left--;
          ofifo_valid = 1'b1;
        end
        3: begin
          data_ready_huff = 1'b1;
          ofifo_valid = drain_flag ? ((pidx < 4) ? pat[pidx] != 0 : 1'b1) : 1'b0;
          if (drain_flag) pidx++;
        end
        default: begin
          data_ready_huff = ($urandom_range(0, 3) != 0);
          ofifo_valid = $urandom_range(0, 1) != 0;
          start = (mode == 5 && cyc == 3);
        end
      endcase
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (done) got_done = 1'b1;
      if (mode == 4 && ex_cnt > 3 && !got_done) begin
        reset = 1'b0;
        #1;
        check("abort_inst_idle", inst, IDLE_W);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        rd_q.delete(); wr_q.delete(); lay_q.delete();
        clear_mon();
        @(negedge clk);
        reset = 1'b1;
        aborted = 1'b1;
      end
    end

    if (mode == 4) begin
      check("abort_reached_exec", aborted, 1);
    end else begin
      check("layer_done_seen", got_done, 1);
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("busy_after_done", busy, 0);
      check("idle_inst_after_done", inst, IDLE_W);
    end
    if (mode == 2) check("stall_checked", stall_checked, 1);
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_inst", inst, IDLE_W);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    reset = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    run_layer(0, 16, 0, 4, 0);
    run_layer(100, 300, 500, 6, 2);
    run_layer(5, 40, 77, 5, 3);
    run_layer(1020, 1022, 2046, 4, 0);
    run_layer(33, 700, 1000, 1, 1);
    run_layer(7, 9, 11, 12, 5);
    run_layer(200, 400, 600, 10, 4);
    run_layer(0, 16, 0, 4, 0);
    for (int i = 0; i < 8; i++) begin
      run_layer($urandom_range(0, 1023), $urandom_range(0, 1023),
                $urandom_range(0, 2047), $urandom_range(1, 40),
                (i % 2 == 0) ? 1 : 5);
    end

    repeat (3) @(negedge clk);
    check("final_rd_q_empty", rd_q.size(), 0);
    check("final_wr_q_empty", wr_q.size(), 0);
    check("final_layers_empty", lay_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
